// File: rtl/byte_frame_serializer.sv
// byte_frame_serializer
// Captures a whole DEPTH-byte frame in a single cycle and drains it one byte
// per valid/ready handshake, starting with byte 0 (the least significant lane).
// A frame may be reloaded on the same cycle its last byte is accepted, so
// frames can stream back-to-back with no idle cycle between them.

module byte_frame_serializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 5,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [WIDTH*DEPTH-1:0] load_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_last,
   output logic [CW-1:0]          count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } stateT;

   stateT                  r_state;
   logic [WIDTH*DEPTH-1:0] r_frame;
   logic [CW-1:0]          r_count;

   logic w_outFire;
   logic w_lastFire;
   logic w_loadFire;

   // Handshake decode; load_ready looks through to out_ready so a new frame
   // can be taken in the very cycle the previous frame's last byte leaves.
   always_comb begin
      w_outFire  = (r_state == SEND) && out_ready;
      w_lastFire = w_outFire && (r_count == CW'(1));
      load_ready = (r_state == IDLE) || w_lastFire;
      w_loadFire = load_valid && load_ready && !clear;
   end

   // Frame state machine: clear wins over everything, then a load, then the
   // final-byte drain back to idle, then an ordinary shift by one lane.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_count <= '0;
      end else if (w_loadFire) begin
         r_state <= SEND;
         r_frame <= load_data;
         r_count <= CW'(DEPTH);
      end else if (w_lastFire) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_count <= '0;
      end else if (w_outFire) begin
         r_frame <= {{WIDTH{1'b0}}, r_frame[WIDTH*DEPTH-1:WIDTH]};
         r_count <= r_count - CW'(1);
      end
   end

   // Outputs come straight from the registers, so they are glitch-free and
   // naturally hold still while the sink applies backpressure.
   always_comb begin
      out_valid = (r_state == SEND);
      out_data  = r_frame[WIDTH-1:0];
      out_last  = (r_count == CW'(1));
      count     = r_count;
   end

endmodule

// File: tb/tb_byte_frame_serializer.sv
// tb_byte_frame_serializer
// Directed stimulus for byte_frame_serializer, checked every cycle against a
// queue-based model of the frame (bytes still owed to the sink), plus literal
// expectations for each scenario.

module tb_byte_frame_serializer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 5;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int FW    = WIDTH * DEPTH;

   logic             clock;
   logic             reset;
   logic             clear;
   logic             load_valid;
   logic             load_ready;
   logic [FW-1:0]    load_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic [CW-1:0]    count;

   int passCount  = 0;
   int totalCount = 0;

   logic [WIDTH-1:0] modelQ[$];
   logic [WIDTH-1:0] acceptedQ[$];

   byte_frame_serializer #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_data (load_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .count     (count)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts one comparison and reports it if it does not hold.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      totalCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs shortly after the rising edge.
   task automatic applyStimulus(input logic lv, input logic [FW-1:0] d, input logic ordy, input logic clr);
      @(posedge clock);
      #1;
      load_valid = lv;
      load_data  = d;
      out_ready  = ordy;
      clear      = clr;
   endtask

   // Compares the accepted-byte log against base+i for n bytes from offset.
   task automatic checkSeq(input string name, input int offset, input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         if (offset + i < acceptedQ.size())
            checkOutput(name, 64'(acceptedQ[offset + i]), 64'(base + 8'(i)));
         else
            checkOutput({name, " missing"}, 64'(acceptedQ.size()), 64'(offset + i + 1));
      end
   endtask

   // Reference model: the frame is just the list of bytes still owed. A load
   // replaces it when empty or when its final byte is being taken; a handshake
   // pops one byte; clear and reset empty it.
   always @(posedge clock or posedge reset) begin
      bit lr;
      if (reset) begin
         modelQ.delete();
      end else if (clear) begin
         modelQ.delete();
      end else begin
         lr = (modelQ.size() == 0) || (modelQ.size() == 1 && out_ready);
         if (load_valid && lr) begin
            modelQ.delete();
            for (int k = 0; k < DEPTH; k++) modelQ.push_back(load_data[k*WIDTH +: WIDTH]);
         end else if (modelQ.size() > 0 && out_ready) begin
            void'(modelQ.pop_front());
         end
      end
   end

   // Every falling edge, the DUT outputs must match what the model owes.
   always @(negedge clock) begin
      int sz;
      sz = modelQ.size();
      checkOutput("model out_valid", 64'(out_valid), 64'(sz != 0));
      checkOutput("model out_data", 64'(out_data), (sz != 0) ? 64'(modelQ[0]) : 64'd0);
      checkOutput("model out_last", 64'(out_last), 64'(sz == 1));
      checkOutput("model count", 64'(count), 64'(sz));
      checkOutput("model load_ready", 64'(load_ready), 64'((sz == 0) || (sz == 1 && out_ready === 1'b1)));
   end

   // Log of bytes the sink actually took.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready && !clear) acceptedQ.push_back(out_data);
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      logic [FW-1:0] frameA;
      logic [FW-1:0] frameB;
      bit            bp[4];
      int            cyc;

      bp     = '{1'b1, 1'b0, 1'b0, 1'b1};
      frameA = 40'h0E0D0C0B0A;
      frameB = 40'h1E1D1C1B1A;

      reset      = 1'b1;
      clear      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      out_ready  = 1'b0;

      // Reset state
      @(negedge clock);
      checkOutput("reset out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset out_data", 64'(out_data), 64'd0);
      checkOutput("reset out_last", 64'(out_last), 64'd0);
      checkOutput("reset count", 64'(count), 64'd0);
      checkOutput("reset load_ready", 64'(load_ready), 64'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Single frame, sink always ready
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h0504030201, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, '0, 1'b1, 1'b0);
         @(negedge clock);
         checkOutput("single out_data", 64'(out_data), 64'(i + 1));
         checkOutput("single count", 64'(count), 64'(DEPTH - i));
         checkOutput("single out_last", 64'(out_last), 64'(i == DEPTH - 1));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("single end out_valid", 64'(out_valid), 64'd0);
      checkOutput("single end count", 64'(count), 64'd0);
      checkSeq("single seq", 0, 8'h01, 5);

      // Backpressure with out_ready toggling 1,0,0,1
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h0504030201, 1'b0, 1'b0);
      cyc = 0;
      while (acceptedQ.size() < 5 && cyc < 40) begin
         applyStimulus(1'b0, '0, bp[cyc % 4], 1'b0);
         @(negedge clock);
         cyc++;
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("backpressure byte total", 64'(acceptedQ.size()), 64'd5);
      checkSeq("backpressure seq", 0, 8'h01, 5);
      checkOutput("backpressure idle", 64'(out_valid), 64'd0);

      // Back-to-back frames
      acceptedQ.delete();
      applyStimulus(1'b1, frameA, 1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         if (i <= 5) applyStimulus(1'b1, frameB, 1'b1, 1'b0);
         else        applyStimulus(1'b0, '0, 1'b1, 1'b0);
         @(negedge clock);
         checkOutput("b2b out_valid", 64'(out_valid), 64'd1);
         if (i <= 5) checkOutput("b2b load_ready", 64'(load_ready), 64'(i == 5));
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("b2b byte total", 64'(acceptedQ.size()), 64'd10);
      checkSeq("b2b frame A", 0, 8'h0A, 5);
      checkSeq("b2b frame B", 5, 8'h1A, 5);

      // Load ignored mid-frame
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h2524232221, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, {FW{1'b1}}, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("ignored count", 64'(count), 64'd3);
      checkOutput("ignored load_ready", 64'(load_ready), 64'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("ignored idle", 64'(out_valid), 64'd0);
      checkSeq("ignored seq", 0, 8'h21, 5);

      // Clear at count 2 with a competing load
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h3534333231, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, 40'hAAAAAAAAAA, 1'b1, 1'b1);
      @(negedge clock);
      checkOutput("clear count before", 64'(count), 64'd2);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("clear out_valid", 64'(out_valid), 64'd0);
      checkOutput("clear count", 64'(count), 64'd0);
      checkOutput("clear byte total", 64'(acceptedQ.size()), 64'd3);
      checkSeq("clear seq", 0, 8'h31, 3);

      // Normal load after clear
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h4544434241, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkSeq("post-clear seq", 0, 8'h41, 5);

      // Clear on the last byte while load_ready reads 1
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h6564636261, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, 40'h7574737271, 1'b1, 1'b1);
      @(negedge clock);
      checkOutput("clear-last count", 64'(count), 64'd1);
      checkOutput("clear-last load_ready", 64'(load_ready), 64'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("clear-last out_valid", 64'(out_valid), 64'd0);
      checkOutput("clear-last byte total", 64'(acceptedQ.size()), 64'd4);

      // Asynchronous reset mid-frame at count 4
      acceptedQ.delete();
      applyStimulus(1'b1, 40'h5554535251, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("async count before", 64'(count), 64'd4);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async out_valid", 64'(out_valid), 64'd0);
      checkOutput("async out_data", 64'(out_data), 64'd0);
      checkOutput("async out_last", 64'(out_last), 64'd0);
      checkOutput("async count", 64'(count), 64'd0);
      checkOutput("async load_ready", 64'(load_ready), 64'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clock);
      checkOutput("async after out_valid", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/byte_frame_serializer.md
# byte_frame_serializer

Parallel-load, byte-serial-out frame unloader: accepts a DEPTH-byte frame in one cycle and presents it one byte per accepted handshake, lowest byte first. It is the transmit-side counterpart of the 8-bit, 5-stage byte delay line, which collects a byte stream into an ordered set of registers. Here a frame is packed and handed off whole, then drained as a stream with valid/ready flow control. Used wherever a stored frame must be streamed back onto a byte bus.

## Interface
- WIDTH, 8, bits per byte lane.
- DEPTH, 5, bytes per frame; legal range 2..16.
- CW, $clog2(DEPTH+1), width of count; derived, not overridden.

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards the frame in progress.
- load_valid  input  1  load_data holds a frame to capture.
- load_ready  output  1  block will capture a frame this cycle.
- load_data  input  WIDTH*DEPTH  frame; byte k = load_data[k*WIDTH +: WIDTH]; byte 0 is sent first.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  sink accepts out_data this cycle.
- out_data  output  WIDTH  current byte.
- out_last  output  1  current byte is the final byte of the frame.
- count  output  CW  bytes remaining in the frame, including the current byte.

## Operation
- FSM states:
  - IDLE: no frame held.
  - SEND: frame held, bytes remaining.
- Frame register: DEPTH×WIDTH shift register, plus count.
- load_ready = (state==IDLE) || (out_valid && out_ready && out_last).
  - Combinational path from out_ready to load_ready, permitted so frames can run back-to-back.
- Load fire (load_valid && load_ready && !clear):
  - Capture all DEPTH bytes; count <= DEPTH; state <= SEND.
- Out fire (out_valid && out_ready) when not the last byte:
  - Register shifts down one lane: byte k <= byte k+1; top lane <= 0; count <= count-1.
- Out fire on the last byte (count==1):
  - If a load fires the same cycle, the new frame is captured (count <= DEPTH, stay SEND).
  - Otherwise state <= IDLE, count <= 0, register <= 0.
- out_valid = (state==SEND). out_data = lane 0. out_last = (count==1).
- Backpressure: while out_valid && !out_ready, out_data, out_last and count are held unchanged.
- clear:
  - Highest synchronous priority.
  - Next cycle: state IDLE, count 0, register 0.
  - A load_valid in the same cycle is ignored, even though load_ready may read 1.
- load_valid while in SEND and not on the last-byte fire: ignored. load_data need not be held.
- The block never drops or duplicates a byte except on clear or reset.

## Timing
- Reset (asynchronous assert; release synchronous to clock by system):
  - state IDLE, out_valid 0, out_data 0, out_last 0, count 0, register 0.
  - load_ready reads 1 during and after reset.
- Latency: a load fire in cycle N gives out_valid=1 with byte 0 in cycle N+1.
- Throughput:
  - With out_ready held high, one frame of DEPTH bytes takes DEPTH cycles.
  - Back-to-back frames run with no gap cycle when load_valid is high on each last-byte fire.
- Reset mid-frame: outputs go to reset values immediately (asynchronous); remaining bytes are lost.
- clear mid-frame: the current out_data is not accepted even if out_ready is high that cycle; out_valid is 0 the next cycle.

## Test plan
- Reset then single frame:
  - Stimulus: load 0x0504030201 with DEPTH=5, out_ready=1.
  - Response: out_data 01,02,03,04,05 in cycles N+1..N+5; out_last only on 05; count 5,4,3,2,1; then out_valid=0 and count=0.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1,...
  - Response: every byte is held while out_ready=0; sequence 01..05 with no loss or repeat.
- Back-to-back frames:
  - Stimulus: load_valid held high with frame A=0x0A..0x0E then B=0x1A..0x1E, out_ready=1.
  - Response: 10 consecutive valid bytes with no bubble; load_ready=1 only in the cycle A's 0x0E is accepted.
- Ignored load:
  - Stimulus: during SEND at count=3, pulse load_valid with 0xFFFFFFFFFF.
  - Response: load_ready=0; the original bytes continue unchanged.
- clear mid-frame:
  - Stimulus: assert clear at count=2 with out_ready=1 and load_valid=1 in the same cycle.
  - Response: next cycle out_valid=0, count=0, state IDLE, no frame captured; a following load works normally.
- Async reset mid-frame:
  - Stimulus: assert reset between clock edges at count=4.
  - Response: out_valid, out_data, out_last and count go to 0 before the next edge; load_ready=1.
